// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - MIPS memory-stage load unit: alignment check, bus request, lane extract
// Accepts one load at a time, issues it on an SRAM-like bus and returns a registered, extended result.
module mem_load_unit #(
  parameter int DW         = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [2:0]    ld_op,
  input  logic [31:0]   ld_addr,
  input  logic          flush,
  output logic          mem_req,
  output logic [31:0]   mem_addr,
  input  logic          mem_addr_ok,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_data_ok,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          res_err,
  output logic [31:0]   res_badaddr
);

  localparam int LSB = $clog2(DW / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]    r_op;
  logic [31:0]   r_addr;
  logic          r_res_valid;
  logic          r_res_err;
  logic [DW-1:0] r_res_data;
  logic [31:0]   r_res_badaddr;

  logic          w_accept;
  logic          w_err;
  logic          w_capture;
  logic [LSB-1:0] w_off;
  logic [DW-1:0] w_shifted;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_word;
  logic [DW-1:0] w_ext;

  assign w_accept  = (r_state == S_IDLE) && ld_valid && !flush;
  assign w_capture = (r_state == S_WAIT) && mem_data_ok && !flush;

  // Misaligned accesses, op 7, and 64-bit-only ops on a 32-bit bus never reach the bus.
  always_comb begin
    w_err = 1'b0;
    case (ld_op)
      3'd2, 3'd3: w_err = ld_addr[0];
      3'd4:       w_err = |ld_addr[1:0];
      3'd5:       w_err = (|ld_addr[1:0]) || (DW == 32);
      3'd6:       w_err = (|ld_addr[2:0]) || (DW == 32);
      3'd7:       w_err = 1'b1;
      default:    w_err = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_err) w_next = S_REQ;
      end
      S_REQ: begin
        if (flush)            w_next = mem_addr_ok ? S_DRAIN : S_IDLE;
        else if (mem_addr_ok) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_data_ok) w_next = S_IDLE;
        else if (flush)  w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (mem_data_ok) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shift the addressed lane to the top (big endian) or bottom (little endian) of the bus word.
  assign w_off     = r_addr[LSB-1:0];
  assign w_shifted = BIG_ENDIAN ? (mem_rdata << {w_off, 3'b000})
                                : (mem_rdata >> {w_off, 3'b000});
  assign w_byte    = BIG_ENDIAN ? w_shifted[DW-1 -: 8]  : w_shifted[7:0];
  assign w_half    = BIG_ENDIAN ? w_shifted[DW-1 -: 16] : w_shifted[15:0];
  assign w_word    = BIG_ENDIAN ? w_shifted[DW-1 -: 32] : w_shifted[31:0];

  always_comb begin
    w_ext = mem_rdata;
    case (r_op)
      3'd0:    w_ext = DW'($signed(w_byte));
      3'd1:    w_ext = DW'(w_byte);
      3'd2:    w_ext = DW'($signed(w_half));
      3'd3:    w_ext = DW'(w_half);
      3'd4:    w_ext = DW'($signed(w_word));
      3'd5:    w_ext = DW'(w_word);
      default: w_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_op          <= 3'd0;
      r_addr        <= 32'd0;
      r_res_valid   <= 1'b0;
      r_res_err     <= 1'b0;
      r_res_data    <= '0;
      r_res_badaddr <= 32'd0;
    end else begin
      r_state     <= w_next;
      r_res_valid <= 1'b0;
      if (w_accept) begin
        r_op   <= ld_op;
        r_addr <= ld_addr;
        if (w_err) begin
          r_res_valid   <= 1'b1;
          r_res_err     <= 1'b1;
          r_res_badaddr <= ld_addr;
          r_res_data    <= '0;
        end
      end else if (w_capture) begin
        r_res_valid   <= 1'b1;
        r_res_err     <= 1'b0;
        r_res_badaddr <= 32'd0;
        r_res_data    <= w_ext;
      end
    end
  end

  // ld_ready is gated by resetn so every output reads 0 while the unit is held in reset.
  assign ld_ready    = (r_state == S_IDLE) && resetn;
  assign mem_req     = (r_state == S_REQ);
  assign mem_addr    = {r_addr[31:LSB], {LSB{1'b0}}};
  assign res_valid   = r_res_valid;
  assign res_err     = r_res_err;
  assign res_data    = r_res_data;
  assign res_badaddr = r_res_badaddr;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb/tb_mem_load_unit.sv - directed and random load checks for mem_load_unit at DW=32 BE and DW=64 LE
module tb_mem_load_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        sel;
  logic        ld_valid;
  logic        flush;
  logic        addr_ok;
  logic        data_ok;
  logic [2:0]  ld_op;
  logic [31:0] ld_addr;
  logic [63:0] rdata;

  logic        a_ready, a_req, a_rv, a_err;
  logic [31:0] a_maddr, a_data, a_bad;
  logic        b_ready, b_req, b_rv, b_err;
  logic [31:0] b_maddr, b_bad;
  logic [63:0] b_data;

  logic        o_ready, o_req, o_rv, o_err;
  logic [31:0] o_maddr, o_bad;
  logic [63:0] o_data;

  int n_pass  = 0;
  int n_total = 0;

  mem_load_unit #(.DW(32), .BIG_ENDIAN(1'b1)) u_dut32 (
    .clk(clk), .resetn(resetn), .ld_valid(ld_valid && !sel), .ld_ready(a_ready),
    .ld_op(ld_op), .ld_addr(ld_addr), .flush(flush), .mem_req(a_req), .mem_addr(a_maddr),
    .mem_addr_ok(addr_ok), .mem_rdata(rdata[31:0]), .mem_data_ok(data_ok),
    .res_valid(a_rv), .res_data(a_data), .res_err(a_err), .res_badaddr(a_bad)
  );

  mem_load_unit #(.DW(64), .BIG_ENDIAN(1'b0)) u_dut64 (
    .clk(clk), .resetn(resetn), .ld_valid(ld_valid && sel), .ld_ready(b_ready),
    .ld_op(ld_op), .ld_addr(ld_addr), .flush(flush), .mem_req(b_req), .mem_addr(b_maddr),
    .mem_addr_ok(addr_ok), .mem_rdata(rdata), .mem_data_ok(data_ok),
    .res_valid(b_rv), .res_data(b_data), .res_err(b_err), .res_badaddr(b_bad)
  );

  assign o_ready = sel ? b_ready : a_ready;
  assign o_req   = sel ? b_req   : a_req;
  assign o_rv    = sel ? b_rv    : a_rv;
  assign o_err   = sel ? b_err   : a_err;
  assign o_maddr = sel ? b_maddr : a_maddr;
  assign o_bad   = sel ? b_bad   : a_bad;
  assign o_data  = sel ? b_data  : {32'd0, a_data};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: bit 64 = error, bits 63:0 = extended result; built from byte lanes, not shifts.
  function automatic logic [64:0] ref_load(input int dw, input bit be, input logic [2:0] op,
                                           input logic [31:0] addr, input logic [63:0] rd);
    int n;
    bit sgn;
    int off;
    logic [63:0] v;
    logic [7:0] lanes [8];
    case (op)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 1; sgn = 0; end
      3'd2: begin n = 2; sgn = 1; end
      3'd3: begin n = 2; sgn = 0; end
      3'd4: begin n = 4; sgn = 1; end
      3'd5: begin n = 4; sgn = 0; end
      3'd6: begin n = 8; sgn = 0; end
      default: begin n = 0; sgn = 0; end
    endcase
    if (n == 0 || (addr % n) != 0 || (dw == 32 && (op == 3'd5 || op == 3'd6)))
      return {1'b1, 64'd0};
    off = int'(addr % (dw / 8));
    for (int k = 0; k < dw / 8; k++)
      lanes[k] = be ? rd[dw-1-8*k -: 8] : rd[8*k +: 8];
    v = 64'd0;
    for (int i = 0; i < n; i++)
      v = be ? {v[55:0], lanes[off+i]} : (v | (64'(lanes[off+i]) << (8 * i)));
    if (sgn && v[8*n-1])
      for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
    if (dw == 32) v[63:32] = 32'd0;
    return {1'b0, v};
  endfunction

  // Starts in a cycle with the unit idle; ends in the result cycle so loads can chain back-to-back.
  task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic [63:0] rd,
                          input int adly, input int ddly);
    logic [64:0] m;
    logic [31:0] exp_ma;
    m = ref_load(sel ? 64 : 32, !sel, op, addr, rd);
    exp_ma = sel ? {addr[31:3], 3'b000} : {addr[31:2], 2'b00};
    chk("ready_idle", o_ready, 1);
    ld_valid = 1'b1; ld_op = op; ld_addr = addr;
    step();
    ld_valid = 1'b0;
    if (m[64]) begin
      chk("err_valid", o_rv, 1);
      chk("err_flag", o_err, 1);
      chk("err_badaddr", o_bad, addr);
      chk("err_data", o_data, 0);
      chk("err_noreq", o_req, 0);
      return;
    end
    chk("accept_rv", o_rv, 0);
    chk("req_rise", o_req, 1);
    chk("mem_addr", o_maddr, exp_ma);
    repeat (adly) begin
      step();
      chk("req_hold", o_req, 1);
      chk("addr_hold", o_maddr, exp_ma);
    end
    addr_ok = 1'b1;
    step();
    addr_ok = 1'b0;
    chk("req_drop", o_req, 0);
    chk("wait_ready", o_ready, 0);
    repeat (ddly - 1) begin
      step();
      chk("wait_rv", o_rv, 0);
    end
    data_ok = 1'b1; rdata = rd;
    step();
    data_ok = 1'b0; rdata = {$urandom, $urandom};
    chk("res_valid", o_rv, 1);
    chk("res_err", o_err, 0);
    chk("res_data", o_data, m[63:0]);
    chk("ready_back", o_ready, 1);
  endtask

  task automatic random_loads(input int count);
    logic [2:0]  op;
    logic [31:0] addr;
    for (int i = 0; i < count; i++) begin
      op   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        case (op)
          3'd2, 3'd3: addr[0] = 1'b0;
          3'd4, 3'd5: addr[1:0] = 2'b00;
          3'd6:       addr[2:0] = 3'b000;
          default:    ;
        endcase
      end
      run_load(op, addr, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(1, 3));
    end
  endtask

  initial begin
    resetn = 1'b0; sel = 1'b0; ld_valid = 1'b0; flush = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; ld_op = 3'd0; ld_addr = 32'd0; rdata = 64'd0;
    #1;
    chk("rst_ready", a_ready, 0);
    chk("rst_req", a_req, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_maddr", a_maddr, 0);
    chk("rst_bad", b_bad, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    step();
    chk("post_rst_ready", a_ready, 1);

    // DW=32 big-endian directed cases
    run_load(3'd0, 32'h1003, 64'h1234_5680, 0, 1);
    chk("tp_lb_neg", o_data, 64'hFFFF_FF80);
    run_load(3'd1, 32'h1003, 64'h1234_5680, 0, 1);
    chk("tp_lbu", o_data, 64'h0000_0080);
    run_load(3'd0, 32'h1000, 64'h1234_5680, 0, 1);
    chk("tp_lb_pos", o_data, 64'h0000_0012);
    run_load(3'd2, 32'h2001, 64'd0, 0, 1);
    chk("tp_lh_bad", o_bad, 32'h2001);
    step();
    chk("err_no_req_later", o_req, 0);
    chk("err_pulse_end", o_rv, 0);
    run_load(3'd6, 32'h3000, 64'd0, 0, 1);
    chk("tp_ld_err", o_err, 1);
    run_load(3'd4, 32'h4000, 64'hCAFE_F00D, 2, 3);

    // flush in WAIT, data arrives two cycles later and is dropped
    ld_valid = 1'b1; ld_op = 3'd4; ld_addr = 32'h5000;
    step(); ld_valid = 1'b0;
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk("drain_ready", o_ready, 0);
    chk("drain_rv", o_rv, 0);
    step();
    data_ok = 1'b1; rdata = 64'h1111_2222;
    chk("drain_ready2", o_ready, 0);
    step(); data_ok = 1'b0;
    chk("drain_done_rv", o_rv, 0);
    chk("drain_done_ready", o_ready, 1);
    run_load(3'd3, 32'h5002, 64'hABCD_8765, 1, 2);

    // flush in REQ withdraws the request
    ld_valid = 1'b1; ld_op = 3'd0; ld_addr = 32'h6001;
    step(); ld_valid = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk("req_flush_req", o_req, 0);
    chk("req_flush_ready", o_ready, 1);
    chk("req_flush_rv", o_rv, 0);

    // flush together with addr_ok drains the response
    ld_valid = 1'b1; ld_op = 3'd1; ld_addr = 32'h6002;
    step(); ld_valid = 1'b0;
    flush = 1'b1; addr_ok = 1'b1; step(); flush = 1'b0; addr_ok = 1'b0;
    chk("req_drain_ready", o_ready, 0);
    data_ok = 1'b1; step(); data_ok = 1'b0;
    chk("req_drain_rv", o_rv, 0);
    chk("req_drain_ready2", o_ready, 1);

    // flush together with data_ok discards the data
    ld_valid = 1'b1; ld_op = 3'd4; ld_addr = 32'h6004;
    step(); ld_valid = 1'b0;
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    flush = 1'b1; data_ok = 1'b1; step(); flush = 1'b0; data_ok = 1'b0;
    chk("wait_flush_rv", o_rv, 0);
    chk("wait_flush_ready", o_ready, 1);

    // flush while idle blocks acceptance
    ld_valid = 1'b1; flush = 1'b1; ld_op = 3'd4; ld_addr = 32'h7000;
    step(); ld_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_req", o_req, 0);
    chk("idle_flush_rv", o_rv, 0);

    // a result already on the output survives a flush
    run_load(3'd2, 32'h7002, 64'h0000_8001, 0, 1);
    flush = 1'b1; #1;
    chk("keep_rv", o_rv, 1);
    chk("keep_data", o_data, 64'hFFFF_8001);
    step(); flush = 1'b0;

    // asynchronous reset while in REQ
    ld_valid = 1'b1; ld_op = 3'd4; ld_addr = 32'h8004;
    step(); ld_valid = 1'b0;
    chk("pre_rst_req", o_req, 1);
    resetn = 1'b0; #1;
    chk("arst_req", o_req, 0);
    chk("arst_ready", o_ready, 0);
    chk("arst_maddr", o_maddr, 0);
    chk("arst_rv", o_rv, 0);
    chk("arst_err", o_err, 0);
    chk("arst_data", o_data, 0);
    @(negedge clk) resetn = 1'b1;
    step();
    run_load(3'd4, 32'h8008, 64'h7654_3210, 0, 1);

    random_loads(40);
    step();

    // DW=64 little-endian
    sel = 1'b1;
    run_load(3'd5, 32'h0000_1004, 64'h8000_0001_0000_0002, 0, 1);
    chk("tp_lwu64", o_data, 64'h0000_0000_8000_0001);
    run_load(3'd4, 32'h0000_1004, 64'h8000_0001_0000_0002, 1, 2);
    chk("tp_lw64", o_data, 64'hFFFF_FFFF_8000_0001);
    run_load(3'd6, 32'h0000_2008, 64'h0123_4567_89AB_CDEF, 0, 1);
    chk("tp_ld64", o_data, 64'h0123_4567_89AB_CDEF);
    random_loads(40);
    step();
    chk("final_rv", o_rv, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Parametrised load-data unit for the MIPS memory stage, replacing the purely combinational byte/half extraction with a full load path. It accepts one load from the pipeline, checks alignment, and issues a request on the data SRAM-like bus. It then waits a variable number of cycles for the response, selects and extends the addressed lane, and returns a registered result. Flush support lets exceptions and branch squashes cancel an in-flight load safely.

## Interface
- DW, 32: data bus width; legal values 32 or 64.
- BIG_ENDIAN, 1: lane order. 1 places byte offset k at bits [DW-1-8k -: 8]; 0 places it at bits [8k+7:8k].

- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- ld_valid  in  1  load request from pipeline
- ld_ready  out  1  unit can accept; high only in IDLE
- ld_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWU, 6 LD, 7 illegal
- ld_addr  in  32  byte address
- flush  in  1  cancel current load
- mem_req  out  1  bus request
- mem_addr  out  32  ld_addr with low log2(DW/8) bits cleared
- mem_addr_ok  in  1  request accepted
- mem_rdata  in  DW  read data
- mem_data_ok  in  1  read data valid
- res_valid  out  1  one-cycle result pulse
- res_data  out  DW  extended load result
- res_err  out  1  address error or illegal op
- res_badaddr  out  32  faulting address, valid with res_err

## Operation
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: if ld_valid and not flush, latch op and addr. Then:
  - Error: the next cycle pulses res_valid=1, res_err=1, res_badaddr=addr, res_data=0, and the state stays IDLE. No bus request is made.
  - No error: go to REQ.
- Error conditions: LH/LHU with addr[0]=1; LW/LWU with addr[1:0]≠0; LD with addr[2:0]≠0; op 7; LWU or LD when DW=32.
- REQ: mem_req=1 with stable mem_addr.
  - mem_addr_ok goes to WAIT.
  - flush without addr_ok goes to IDLE (request withdrawn).
  - flush with addr_ok goes to DRAIN.
- WAIT: mem_data_ok loads the result registers and goes to IDLE. flush goes to DRAIN. flush and data_ok in the same cycle discards the data and goes to IDLE.
- DRAIN: wait for mem_data_ok, discard it, go to IDLE. No res_valid is produced.
- Extraction: the lane is selected by the address bits below DW/8 using BIG_ENDIAN order.
  - LB/LH/LW sign-extend to DW; LBU/LHU/LWU zero-extend.
  - LD and (for DW=32) LW pass the full word.
- A res_valid already asserted is never retracted by a later flush.

## Timing
- Reset values: state IDLE; mem_req, res_valid, res_err 0; res_data, res_badaddr, mem_addr 0; ld_ready 1 once resetn is high.
- Accept at cycle T. mem_req is high from T+1. If addr_ok arrives at T+1 and data_ok at T+2, res_valid is at T+3. This is the minimum hit latency of 3 cycles.
- mem_data_ok never coincides with the mem_addr_ok of the same request. The bus keeps at most one request outstanding.
- ld_ready is combinational from state, so back-to-back loads are accepted on the cycle res_valid is high.
- resetn low at any point returns the unit to IDLE asynchronously and clears all outputs. The bus is reset together with the unit.

## Test plan
- DW=32, BIG_ENDIAN=1: LB addr 0x1003, rdata 0x1234_5680 gives res_data 0xFFFF_FF80. LBU at the same address gives 0x0000_0080. LB addr 0x1000 gives 0x0000_0012.
- DW=32: LH addr 0x2001 gives a res_valid pulse at T+1 with res_err=1 and res_badaddr=0x2001, and mem_req never rises. LD gives res_err=1.
- Latency: addr_ok delayed 2 cycles and data_ok 3 cycles later gives res_valid exactly one cycle after data_ok, with mem_addr held stable throughout.
- Flush in WAIT, then data_ok 2 cycles later: no res_valid, ld_ready low until the cycle after data_ok, and the next load completes normally.
- DW=64, BIG_ENDIAN=0: LWU addr 0x…04, rdata 0x8000_0001_0000_0002 gives 0x0000_0000_8000_0001. LW at the same address gives 0xFFFF_FFFF_8000_0001.
- resetn pulsed low in REQ: mem_req drops immediately, all outputs are 0, and the unit accepts a new load after resetn rises.
